ks_coef_decomp: RTL and testbench
=================================

// Module: ks_coef_decomp
// PURPOSE
//   Keyswitch input stage of the HPU.
//   - Takes one 64-bit LWE coefficient (mod Q, post-PBS) per handshake.
//   - Rounds it to the top KS_L*KS_B_W bits.
//   - Streams KS_L signed balanced digits, one per cycle, to the KSK multiply-accumulate.
//   - Sits between the sample-extract output and the keyswitch MAC.
// PARAMETERS
//   MOD_Q_W  64  input coefficient width (mod 2^MOD_Q_W)
//   KS_L      8  number of decomposition levels
//   KS_B_W    2  decomposition base width in bits (B = 2^KS_B_W)
//   Elaboration check: KS_L*KS_B_W < MOD_Q_W and KS_B_W >= 1; otherwise $fatal.
// PORTS
//   clk           in   1                 clock
//   a_rst         in   1                 reset, asynchronous, active-high
//   in_vld        in   1                 coefficient valid
//   in_rdy        out  1                 coefficient accepted when in_vld & in_rdy
//   in_coef       in   MOD_Q_W           coefficient, unsigned mod 2^MOD_Q_W
//   in_last       in   1                 last coefficient of the LWE (body)
//   out_vld       out  1                 digit valid
//   out_rdy       in   1                 downstream accepts digit when out_vld & out_rdy
//   out_digit     out  KS_B_W            signed two's-complement digit in [-B/2, B/2-1]
//   out_lvl       out  $clog2(KS_L)      level index, 0 = least significant
//   out_lvl_last  out  1                 out_lvl == KS_L-1
//   out_coef_last out  1                 registered in_last of the coefficient being emitted
// BEHAVIOUR
//   Reset (a_rst high, async)
//     - State IDLE; out_vld=0, out_digit=0, out_lvl=0, out_lvl_last=0, out_coef_last=0.
//     - in_rdy=0 while a_rst is high.
//   Rounding, on accept
//     - Let S = MOD_Q_W - KS_L*KS_B_W.
//     - r = (in_coef >> S) + in_coef[S-1], computed mod 2^(KS_L*KS_B_W); carry-out is discarded.
//     - r and in_last are registered, together with the initial carry c = 0.
//   Digit, level i
//     - d = r[i*KS_B_W +: KS_B_W] + c.
//     - If d >= B/2: digit = d - B, next c = 1. Else digit = d, next c = 0.
//     - The final carry after level KS_L-1 is discarded (wraps mod 2^(KS_L*KS_B_W)).
//   FSM
//     - IDLE: in_rdy=1. On accept, go to EMIT with lvl=0; out_vld=1 the next cycle (latency 1).
//     - EMIT: out_vld=1. On out_vld & out_rdy, lvl increments.
//         - Handshake at lvl==KS_L-1 with in_vld=1: accept the next coefficient in the same cycle, stay in EMIT, lvl=0.
//         - Handshake at lvl==KS_L-1 with in_vld=0: return to IDLE.
//     - in_rdy = (state==IDLE) | (state==EMIT & out_lvl_last & out_rdy).
//       This is combinational from out_rdy; no other path exists.
//     - Sustained throughput: 1 digit/cycle, KS_L cycles per coefficient, no bubble.
//   Backpressure
//     - While out_vld & !out_rdy, out_digit, out_lvl, out_lvl_last and out_coef_last hold stable.
//   Reset mid-EMIT
//     - The remaining digits are dropped and out_vld falls asynchronously.
//     - After release, the block is in IDLE and in_rdy=1 on the first clock edge.
// TESTING
//   1. in_coef=0 -> 8 digits, all 2'b00, out_lvl 0..7, out_lvl_last only on lvl 7.
//   2. in_coef=2^63 -> r=0x8000 -> lvl0..6=0, lvl7 digit=-2 (2'b10); final carry dropped.
//   3. in_coef=2^47 (round bit only) -> r=1 -> lvl0=1, others 0.
//      in_coef=0xFFFF_8000_0000_0000 -> r wraps to 0 -> all digits 0.
//   4. in_coef=0x0003_0000_0000_0000 -> lvl0=-1 (2'b11), lvl1=1, lvl2..7=0.
//      Random sweep: sum(digit_i * 4^i) mod 2^16 == r.
//   5. Back-to-back: in_vld held high for 3 coefficients, out_rdy=1 -> 24 consecutive valid digits.
//      in_rdy pulses on lvl7 only; out_coef_last=1 on the 3rd coefficient (in_last).
//   6. out_rdy low 3 cycles at lvl2 -> outputs frozen.
//      Assert a_rst at lvl5 -> out_vld=0 immediately; after release in_rdy=1 and a fresh coefficient decomposes correctly.

Source files
------------

// File: rtl/ks_coef_decomp.sv
// Keyswitch input stage: rounds a mod-2^MOD_Q_W coefficient to its top
// KS_L*KS_B_W bits and streams KS_L signed balanced digits, LSB level first.
//
// Ports:
//   clk, a_rst                  clock, async active-high reset
//   in_vld/in_rdy/in_coef/in_last   coefficient handshake
//   out_vld/out_rdy             digit handshake
//   out_digit                   two's-complement digit in [-B/2, B/2-1]
//   out_lvl/out_lvl_last        level index and last-level flag
//   out_coef_last               in_last of the coefficient being emitted
module ks_coef_decomp #(
    parameter int MOD_Q_W = 64,
    parameter int KS_L    = 8,
    parameter int KS_B_W  = 2
) (
    input  logic                    clk,
    input  logic                    a_rst,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [MOD_Q_W-1:0]      in_coef,
    input  logic                    in_last,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [KS_B_W-1:0]       out_digit,
    output logic [$clog2(KS_L)-1:0] out_lvl,
    output logic                    out_lvl_last,
    output logic                    out_coef_last
);

    localparam int RW    = KS_L * KS_B_W;
    localparam int S     = MOD_Q_W - RW;
    localparam int LVL_W = $clog2(KS_L);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(KS_L - 1);

    generate
        if (!(RW < MOD_Q_W) || KS_B_W < 1) begin : g_bad_param
            $fatal(1, "ks_coef_decomp: need KS_L*KS_B_W < MOD_Q_W and KS_B_W >= 1");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t          state;
    logic [RW-1:0]   rem;
    logic            carry;

    logic            accept;
    logic            advance;
    logic [RW-1:0]   r_new;
    logic [KS_B_W:0] st_acc;
    logic [KS_B_W:0] st_adv;
    logic [LVL_W-1:0] lvl_nxt;

    // Bits below the rounding bit do not affect the result.
    logic unused_low;
    assign unused_low = &{1'b0, in_coef[S-2:0]};

    // One balanced-digit step: returns {carry_out, digit}.
    // d >= B/2 means d's top bit or bit KS_B_W-1 is set; the digit is then
    // d - B, which is exactly the low KS_B_W bits of d.
    function automatic logic [KS_B_W:0] dig_step(
        input logic [KS_B_W-1:0] low,
        input logic              cin
    );
        logic [KS_B_W:0] d;
        d = {1'b0, low} + {{KS_B_W{1'b0}}, cin};
        return {d[KS_B_W] | d[KS_B_W-1], d[KS_B_W-1:0]};
    endfunction

    assign advance = out_vld & out_rdy;
    assign in_rdy  = !a_rst &
                     ((state == IDLE) |
                      ((state == EMIT) & out_lvl_last & out_rdy));
    assign accept  = in_vld & in_rdy;

    always_comb begin
        r_new   = in_coef[MOD_Q_W-1:S] + RW'(in_coef[S-1]);
        st_acc  = dig_step(r_new[KS_B_W-1:0], 1'b0);
        st_adv  = dig_step(rem[KS_B_W-1:0], carry);
        lvl_nxt = out_lvl + LVL_W'(1);
    end

    // rem holds the not-yet-emitted levels, shifted down so the next
    // digit always comes from the bottom KS_B_W bits.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state         <= IDLE;
            rem           <= '0;
            carry         <= 1'b0;
            out_vld       <= 1'b0;
            out_digit     <= '0;
            out_lvl       <= '0;
            out_lvl_last  <= 1'b0;
            out_coef_last <= 1'b0;
        end else if (accept) begin
            state         <= EMIT;
            rem           <= r_new >> KS_B_W;
            carry         <= st_acc[KS_B_W];
            out_vld       <= 1'b1;
            out_digit     <= st_acc[KS_B_W-1:0];
            out_lvl       <= '0;
            out_lvl_last  <= (KS_L == 1);
            out_coef_last <= in_last;
        end else if (advance) begin
            if (out_lvl_last) begin
                state   <= IDLE;
                out_vld <= 1'b0;
            end else begin
                rem          <= rem >> KS_B_W;
                carry        <= st_adv[KS_B_W];
                out_digit    <= st_adv[KS_B_W-1:0];
                out_lvl      <= lvl_nxt;
                out_lvl_last <= (lvl_nxt == LVL_MAX);
            end
        end
    end

endmodule

// File: tb/tb_ks_coef_decomp.sv
// Directed testbench for ks_coef_decomp (default parameters: 64-bit
// coefficient, 8 levels, base 4).
module tb_ks_coef_decomp;

    logic        clk = 1'b0;
    logic        a_rst;
    logic        in_vld;
    logic        in_rdy;
    logic [63:0] in_coef;
    logic        in_last;
    logic        out_vld;
    logic        out_rdy;
    logic [1:0]  out_digit;
    logic [2:0]  out_lvl;
    logic        out_lvl_last;
    logic        out_coef_last;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    ks_coef_decomp dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_coef      (in_coef),
        .in_last      (in_last),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_digit    (out_digit),
        .out_lvl      (out_lvl),
        .out_lvl_last (out_lvl_last),
        .out_coef_last(out_coef_last)
    );

    task automatic step_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] c, input logic last,
                        output bit tmo);
        in_coef = c;
        in_last = last;
        in_vld  = 1'b1;
        tmo     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_rdy) begin
                tmo = 1'b0;
                break;
            end
            step_clk();
        end
        step_clk();
        in_vld = 1'b0;
    endtask

    task automatic collect(output logic [15:0] dig, output int bad);
        bad = 0;
        dig = '0;
        for (int i = 0; i < 8; i++) begin
            if (out_vld !== 1'b1 || out_lvl !== 3'(i) ||
                out_lvl_last !== (i == 7))
                bad++;
            dig[2*i +: 2] = out_digit;
            step_clk();
        end
    endtask

    task automatic run_coef(input logic [63:0] c, input logic last,
                            output logic [15:0] dig, output int bad);
        bit tmo;
        send(c, last, tmo);
        collect(dig, bad);
        if (tmo)
            bad += 100;
    endtask

    task automatic test_reset;
        a_rst   = 1'b0;
        in_vld  = 1'b0;
        in_coef = '0;
        in_last = 1'b0;
        out_rdy = 1'b1;
        #1 a_rst = 1'b1;
        #2;
        ntot++;
        if ({out_vld, out_digit, out_lvl, out_lvl_last, out_coef_last} !== 8'h00)
            $display("FAIL reset_outputs got %b expected 0",
                     {out_vld, out_digit, out_lvl, out_lvl_last, out_coef_last});
        else npass++;
        ntot++;
        if (in_rdy !== 1'b0)
            $display("FAIL reset_in_rdy got %b expected 0", in_rdy);
        else npass++;
        step_clk();
        step_clk();
        a_rst = 1'b0;
        #1;
        ntot++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0)
            $display("FAIL reset_release got rdy=%b vld=%b expected rdy=1 vld=0",
                     in_rdy, out_vld);
        else npass++;
    endtask

    task automatic test_zero;
        logic [15:0] dig;
        int bad;
        run_coef(64'h0, 1'b0, dig, bad);
        ntot++;
        if (dig !== 16'h0000)
            $display("FAIL zero_digits got %h expected 0000", dig);
        else npass++;
        ntot++;
        if (bad !== 0)
            $display("FAIL zero_levels got %0d errors expected 0", bad);
        else npass++;
        ntot++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1)
            $display("FAIL zero_idle got vld=%b rdy=%b expected vld=0 rdy=1",
                     out_vld, in_rdy);
        else npass++;
    endtask

    task automatic test_msb;
        logic [15:0] dig;
        int bad;
        run_coef(64'h8000_0000_0000_0000, 1'b0, dig, bad);
        ntot++;
        if (dig !== 16'h8000 || bad !== 0)
            $display("FAIL msb_digits got %h/%0d expected 8000/0", dig, bad);
        else npass++;
    endtask

    task automatic test_round;
        logic [15:0] dig;
        int bad;
        run_coef(64'h0000_8000_0000_0000, 1'b0, dig, bad);
        ntot++;
        if (dig !== 16'h0001 || bad !== 0)
            $display("FAIL round_up got %h/%0d expected 0001/0", dig, bad);
        else npass++;
        run_coef(64'hFFFF_8000_0000_0000, 1'b0, dig, bad);
        ntot++;
        if (dig !== 16'h0000 || bad !== 0)
            $display("FAIL round_wrap got %h/%0d expected 0000/0", dig, bad);
        else npass++;
    endtask

    task automatic test_carry;
        logic [15:0] dig;
        logic [15:0] r;
        logic [15:0] acc;
        logic [63:0] c;
        int bad;
        run_coef(64'h0003_0000_0000_0000, 1'b0, dig, bad);
        ntot++;
        if (dig !== 16'h0007 || bad !== 0)
            $display("FAIL carry_3 got %h/%0d expected 0007/0", dig, bad);
        else npass++;
        run_coef(64'hAAAA_0000_0000_0000, 1'b0, dig, bad);
        ntot++;
        if (dig !== 16'hFFFE || bad !== 0)
            $display("FAIL carry_chain got %h/%0d expected FFFE/0", dig, bad);
        else npass++;
        for (int k = 0; k < 6; k++) begin
            c = {$urandom, $urandom};
            r = c[63:48] + {15'b0, c[47]};
            run_coef(c, 1'b0, dig, bad);
            acc = '0;
            for (int i = 0; i < 8; i++)
                acc += {{14{dig[2*i+1]}}, dig[2*i +: 2]} << (2 * i);
            ntot++;
            if (acc !== r || bad !== 0)
                $display("FAIL sweep coef=%h got %h/%0d expected %h/0",
                         c, acc, bad, r);
            else npass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] coefs [3];
        logic [15:0] exp_d [3];
        int k, n, first, lastc, pulses, rdy_bad, dig_bad, cl_bad;
        bit will_acc;
        coefs[0] = 64'h0;                   exp_d[0] = 16'h0000;
        coefs[1] = 64'h0000_8000_0000_0000; exp_d[1] = 16'h0001;
        coefs[2] = 64'h0003_0000_0000_0000; exp_d[2] = 16'h0007;
        k = 0; n = 0; first = -1; lastc = -1;
        pulses = 0; rdy_bad = 0; dig_bad = 0; cl_bad = 0;
        out_rdy = 1'b1;
        in_coef = coefs[0];
        in_last = 1'b0;
        in_vld  = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_vld) begin
                if (first < 0) first = cyc;
                lastc = cyc;
                if (in_rdy) pulses++;
                if (in_rdy !== out_lvl_last) rdy_bad++;
                if (n < 24) begin
                    if (out_digit !== exp_d[n/8][2*(n%8) +: 2] ||
                        out_lvl !== 3'(n % 8))
                        dig_bad++;
                    if (out_coef_last !== (n / 8 == 2)) cl_bad++;
                end
                n++;
            end
            will_acc = in_vld & in_rdy;
            step_clk();
            if (will_acc) begin
                k++;
                if (k < 3) begin
                    in_coef = coefs[k];
                    in_last = (k == 2);
                end else begin
                    in_vld = 1'b0;
                end
            end
        end
        in_vld = 1'b0;
        ntot++;
        if (n !== 24 || lastc - first + 1 !== 24)
            $display("FAIL b2b_count got %0d digits over %0d cycles expected 24/24",
                     n, lastc - first + 1);
        else npass++;
        ntot++;
        if (dig_bad !== 0)
            $display("FAIL b2b_digits got %0d errors expected 0", dig_bad);
        else npass++;
        ntot++;
        if (pulses !== 3 || rdy_bad !== 0)
            $display("FAIL b2b_in_rdy got %0d pulses/%0d errors expected 3/0",
                     pulses, rdy_bad);
        else npass++;
        ntot++;
        if (cl_bad !== 0)
            $display("FAIL b2b_coef_last got %0d errors expected 0", cl_bad);
        else npass++;
    endtask

    task automatic test_backpressure_reset;
        logic [15:0] dig;
        int bad;
        bit tmo;
        out_rdy = 1'b1;
        send(64'hAAAA_0000_0000_0000, 1'b1, tmo);
        ntot++;
        if (tmo)
            $display("FAIL bp_send got timeout expected accept");
        else npass++;
        step_clk();
        step_clk();
        ntot++;
        if (out_lvl !== 3'd2 || out_digit !== 2'b11)
            $display("FAIL bp_lvl2 got lvl=%0d dig=%b expected 2/11",
                     out_lvl, out_digit);
        else npass++;
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            ntot++;
            if ({out_vld, out_lvl, out_digit, out_lvl_last, out_coef_last, in_rdy}
                !== {1'b1, 3'd2, 2'b11, 1'b0, 1'b1, 1'b0})
                $display("FAIL bp_hold%0d got %b expected 1010110010", i,
                         {out_vld, out_lvl, out_digit, out_lvl_last,
                          out_coef_last, in_rdy});
            else npass++;
        end
        out_rdy = 1'b1;
        step_clk();
        step_clk();
        step_clk();
        ntot++;
        if (out_lvl !== 3'd5 || out_vld !== 1'b1)
            $display("FAIL bp_lvl5 got lvl=%0d vld=%b expected 5/1",
                     out_lvl, out_vld);
        else npass++;
        a_rst = 1'b1;
        #1;
        ntot++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b0 || out_lvl !== 3'd0)
            $display("FAIL rst_mid got vld=%b rdy=%b lvl=%0d expected 0/0/0",
                     out_vld, in_rdy, out_lvl);
        else npass++;
        step_clk();
        a_rst = 1'b0;
        #1;
        ntot++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0)
            $display("FAIL rst_release got rdy=%b vld=%b expected 1/0",
                     in_rdy, out_vld);
        else npass++;
        run_coef(64'h0003_0000_0000_0000, 1'b0, dig, bad);
        ntot++;
        if (dig !== 16'h0007 || bad !== 0)
            $display("FAIL rst_fresh got %h/%0d expected 0007/0", dig, bad);
        else npass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero();
        test_msb();
        test_round();
        test_carry();
        test_back_to_back();
        test_backpressure_reset();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
